// File: rtl/riscv32_alu_arbiter.sv
// Two-port round-robin front end for one shared combinational riscv32i_alu.
// Each port gets a one-entry registered response slot with valid/ready on both sides.
module riscv32_alu_arbiter #(
    parameter int              FUN_W   = 5,
    parameter logic [FUN_W-1:0] NOP_FUN = '0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_op1,
    input  logic [31:0]      req0_op2,
    input  logic [FUN_W-1:0] req0_fun,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic             rsp0_br_flg,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_op1,
    input  logic [31:0]      req1_op2,
    input  logic [FUN_W-1:0] req1_fun,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic             rsp1_br_flg,

    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [FUN_W-1:0] alu_fun,
    input  logic [31:0]      alu_result,
    input  logic             alu_br_flg
);

    logic        r_full0, r_full1;
    logic [31:0] r_result0, r_result1;
    logic        r_br0, r_br1;
    logic        r_last;

    logic w_free0, w_free1;
    logic w_elig0, w_elig1;
    logic w_grant0, w_grant1;

    // A slot that is being drained this cycle can accept the next result.
    assign w_free0 = ~r_full0 | rsp0_ready;
    assign w_free1 = ~r_full1 | rsp1_ready;

    // Requests are refused during reset so nothing is accepted into a slot being cleared.
    assign w_elig0 = req0_valid & w_free0 & ~rst;
    assign w_elig1 = req1_valid & w_free1 & ~rst;

    assign w_grant0 = w_elig0 & (~w_elig1 | r_last);
    assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        alu_fun = NOP_FUN;
        if (w_grant0) begin
            alu_op1 = req0_op1;
            alu_op2 = req0_op2;
            alu_fun = req0_fun;
        end else if (w_grant1) begin
            alu_op1 = req1_op1;
            alu_op2 = req1_op2;
            alu_fun = req1_fun;
        end
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full0   <= 1'b0;
            r_full1   <= 1'b0;
            r_result0 <= '0;
            r_result1 <= '0;
            r_br0     <= 1'b0;
            r_br1     <= 1'b0;
            r_last    <= 1'b1;
        end else begin
            if (w_grant0) begin
                r_full0   <= 1'b1;
                r_result0 <= alu_result;
                r_br0     <= alu_br_flg;
            end else if (rsp0_ready) begin
                r_full0   <= 1'b0;
            end

            if (w_grant1) begin
                r_full1   <= 1'b1;
                r_result1 <= alu_result;
                r_br1     <= alu_br_flg;
            end else if (rsp1_ready) begin
                r_full1   <= 1'b0;
            end

            if (w_grant0) begin
                r_last <= 1'b0;
            end else if (w_grant1) begin
                r_last <= 1'b1;
            end
        end
    end

    assign rsp0_valid  = r_full0;
    assign rsp0_result = r_result0;
    assign rsp0_br_flg = r_br0;
    assign rsp1_valid  = r_full1;
    assign rsp1_result = r_result1;
    assign rsp1_br_flg = r_br1;

endmodule

// File: tb/tb_riscv32_alu_arbiter.sv
// Scoreboard bench for riscv32_alu_arbiter with a behavioural model of the shared ALU.
// Directed stimulus carries hand-computed expected responses into per-port queues.
module tb_riscv32_alu_arbiter;

    localparam int FUN_W = 5;
    localparam logic [FUN_W-1:0] NOP      = 5'd0;
    localparam logic [FUN_W-1:0] ALU_ADD  = 5'd1;
    localparam logic [FUN_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [FUN_W-1:0] ALU_OR   = 5'd4;
    localparam logic [FUN_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [FUN_W-1:0] ALU_SLT  = 5'd9;
    localparam logic [FUN_W-1:0] BR_BEQ   = 5'd11;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_br_flg;
    logic [31:0]      req0_op1, req0_op2, rsp0_result;
    logic [FUN_W-1:0] req0_fun;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_br_flg;
    logic [31:0]      req1_op1, req1_op2, rsp1_result;
    logic [FUN_W-1:0] req1_fun;
    logic [31:0]      alu_op1, alu_op2, alu_result;
    logic [FUN_W-1:0] alu_fun;
    logic             alu_br_flg;

    logic [31:0] exp0_res, exp1_res;
    logic        exp0_br, exp1_br;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv32_alu_arbiter #(.FUN_W(FUN_W), .NOP_FUN(NOP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_fun(req0_fun),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_br_flg(rsp0_br_flg),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_fun(req1_fun),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_br_flg(rsp1_br_flg),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_fun(alu_fun),
        .alu_result(alu_result), .alu_br_flg(alu_br_flg)
    );

    // Shared ALU stand-in; branch functions return result 0 and set br_flg.
    always_comb begin
        alu_result = '0;
        alu_br_flg = 1'b0;
        case (alu_fun)
            ALU_ADD: alu_result = alu_op1 + alu_op2;
            ALU_SUB: alu_result = alu_op1 - alu_op2;
            ALU_OR:  alu_result = alu_op1 | alu_op2;
            ALU_XOR: alu_result = alu_op1 ^ alu_op2;
            ALU_SLT: alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
            BR_BEQ:  alu_br_flg = (alu_op1 == alu_op2);
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue tracker: an accepted request pushes the expected response for its port.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_valid && req0_ready) q0.push_back({exp0_br, exp0_res});
            if (req1_valid && req1_ready) q1.push_back({exp1_br, exp1_res});
        end
    end

    // Monitor: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) check("rsp0_unexpected", rsp0_result, 32'hDEAD_BEEF);
                else begin
                    e = q0.pop_front();
                    check("rsp0_result", rsp0_result, e[31:0]);
                    check("rsp0_br_flg", {31'd0, rsp0_br_flg}, {31'd0, e[32]});
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) check("rsp1_unexpected", rsp1_result, 32'hDEAD_BEEF);
                else begin
                    e = q1.pop_front();
                    check("rsp1_result", rsp1_result, e[31:0]);
                    check("rsp1_br_flg", {31'd0, rsp1_br_flg}, {31'd0, e[32]});
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [FUN_W-1:0] f, input logic [31:0] er, input logic eb);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_fun = f;
        exp0_res = er; exp0_br = eb;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [FUN_W-1:0] f, input logic [31:0] er, input logic eb);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_fun = f;
        exp1_res = er; exp1_br = eb;
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b0, 0, 0, NOP, 0, 1'b0);
        drive1(1'b0, 0, 0, NOP, 0, 1'b0);

        // Reset held two cycles; requests are refused while rst is high.
        mid();
        check("rst_req0_ready", {31'd0, req0_ready}, 0);
        check("rst_alu_fun", {27'd0, alu_fun}, {27'd0, NOP});
        next();
        drive0(1'b1, 5, 7, ALU_ADD, 12, 1'b0);
        mid();
        check("rst_ready_gated", {31'd0, req0_ready}, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
        check("rst_rsp0_result", rsp0_result, 0);
        check("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);

        // Single issue: ADD 5,7 -> 12 one cycle later.
        next();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        mid();
        check("issue_req0_ready", {31'd0, req0_ready}, 1);
        check("issue_alu_fun", {27'd0, alu_fun}, {27'd0, ALU_ADD});
        check("issue_alu_op1", alu_op1, 5);
        next();
        drive0(1'b0, 0, 0, NOP, 0, 1'b0);
        mid();
        check("lat_rsp0_valid", {31'd0, rsp0_valid}, 1);
        check("lat_rsp0_result", rsp0_result, 12);
        check("lat_rsp1_valid", {31'd0, rsp1_valid}, 0);
        next();
        mid();
        check("drained_rsp0_valid", {31'd0, rsp0_valid}, 0);

        // Contention: port 0 won last, so the first tie goes to port 1, then alternates.
        next();
        rsp1_ready = 1'b1;
        drive0(1'b1, 10, 3, ALU_SUB, 7, 1'b0);
        drive1(1'b1, 32'hF0, 32'hFF, ALU_XOR, 32'h0F, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mid();
            check("rr_req1_ready", {31'd0, req1_ready}, (i % 2 == 0) ? 1 : 0);
            check("rr_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 0 : 1);
            check("rr_alu_fun", {27'd0, alu_fun}, (i % 2 == 0) ? 32'(ALU_XOR) : 32'(ALU_SUB));
            next();
        end
        drive0(1'b0, 0, 0, NOP, 0, 1'b0);
        drive1(1'b0, 0, 0, NOP, 0, 1'b0);
        next();

        // Backpressure on port 1: BEQ 4,4 sits in the slot while port 0 streams.
        rsp1_ready = 1'b0;
        drive1(1'b1, 4, 4, BR_BEQ, 0, 1'b1);
        mid();
        check("bp_req1_ready", {31'd0, req1_ready}, 1);
        next();
        drive1(1'b0, 0, 0, NOP, 0, 1'b0);
        mid();
        check("bp_rsp1_valid", {31'd0, rsp1_valid}, 1);
        check("bp_rsp1_br_flg", {31'd0, rsp1_br_flg}, 1);
        next();
        drive1(1'b1, 1, 1, ALU_ADD, 2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive0(1'b1, 100 + k, 1, ALU_ADD, 101 + k, 1'b0);
            mid();
            check("bp_req1_blocked", {31'd0, req1_ready}, 0);
            check("bp_req0_ready", {31'd0, req0_ready}, 1);
            check("bp_rsp1_hold", {31'd0, rsp1_valid & rsp1_br_flg}, 1);
            next();
        end
        rsp1_ready = 1'b1;
        drive0(1'b1, 200, 1, ALU_ADD, 201, 1'b0);
        mid();
        check("bp_release_req1", {31'd0, req1_ready}, 1);
        check("bp_release_req0", {31'd0, req0_ready}, 0);
        next();
        drive1(1'b0, 0, 0, NOP, 0, 1'b0);
        mid();
        check("bp_after_req0", {31'd0, req0_ready}, 1);
        next();
        drive0(1'b0, 0, 0, NOP, 0, 1'b0);
        next();

        // Back-to-back SLT stream: responses 1,0,0,1 with no bubble.
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive0(1'b1, 32'hFFFF_FFFF, 0, ALU_SLT, 1, 1'b0);
                1: drive0(1'b1, 0, 32'hFFFF_FFFF, ALU_SLT, 0, 1'b0);
                2: drive0(1'b1, 3, 3, ALU_SLT, 0, 1'b0);
                3: drive0(1'b1, 2, 5, ALU_SLT, 1, 1'b0);
                default: drive0(1'b0, 0, 0, NOP, 0, 1'b0);
            endcase
            mid();
            if (i < 4) check("slt_req0_ready", {31'd0, req0_ready}, 1);
            if (i > 0) check("slt_rsp0_valid", {31'd0, rsp0_valid}, 1);
            next();
        end

        // Idle: nothing valid.
        mid();
        check("idle_alu_op1", alu_op1, 0);
        check("idle_alu_op2", alu_op2, 0);
        check("idle_alu_fun", {27'd0, alu_fun}, {27'd0, NOP});
        check("idle_ready", {30'd0, req1_ready, req0_ready}, 0);

        // Reset while port 0 has a pending response and presents a new request.
        next();
        rsp0_ready = 1'b0;
        drive0(1'b1, 9, 9, ALU_ADD, 18, 1'b0);
        mid();
        check("pre_rst_req0_ready", {31'd0, req0_ready}, 1);
        next();
        rst = 1'b1;
        drive0(1'b1, 1, 2, ALU_OR, 3, 1'b0);
        mid();
        check("midrst_rsp0_valid", {31'd0, rsp0_valid}, 1);
        check("midrst_req0_ready", {31'd0, req0_ready}, 0);
        next();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        drive0(1'b0, 0, 0, NOP, 0, 1'b0);
        mid();
        check("postrst_rsp0_valid", {31'd0, rsp0_valid}, 0);
        check("postrst_rsp0_result", rsp0_result, 0);
        next();
        drive0(1'b1, 1, 2, ALU_ADD, 3, 1'b0);
        drive1(1'b1, 3, 1, ALU_XOR, 2, 1'b0);
        mid();
        check("postrst_tie_req0", {31'd0, req0_ready}, 1);
        check("postrst_tie_req1", {31'd0, req1_ready}, 0);
        next();
        drive0(1'b0, 0, 0, NOP, 0, 1'b0);
        mid();
        check("postrst_req1_ready", {31'd0, req1_ready}, 1);
        next();
        drive1(1'b0, 0, 0, NOP, 0, 1'b0);
        next();
        next();
        mid();
        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
